uart_tx_arbiter: RTL and testbench

- Shares the single board UART transmitter (uart_sender, 115200 baud from the 50 MHz clock) between NUM_REQ on-chip requesters, e.g. the quantum-compiler result dump and debug/status streams.
- Accepts bytes over per-requester valid/ready handshakes and arbitrates round-robin.
- Holds a grant across a multi-byte packet, so packets never interleave on the wire.
- Drives uart_sender's data_to_send / data_to_send_ready, and paces itself by counting the frame time.

---
 rtl/uart_arb_pkg.sv | 24 ++
 rtl/uart_tx_arbiter_rr_pick.sv | 36 +++
 rtl/uart_tx_arbiter.sv | 165 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_arb_pkg
// Description : Shared types and helpers for the board UART transmit arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_arb_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND   = 2'd1,
        WAIT   = 2'd2,
        LOCKED = 2'd3
    } arb_state_t;

    // One start bit, the data bits and the stop bits.
    function automatic int frame_cycles(input int clks_per_bit, input int stop_bits);
        return clks_per_bit * (1 + UART_DATA_BITS + stop_bits);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker; scans upward from ptr+1.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] win_onehot,
    output logic [IDX_W-1:0]   win_idx,
    output logic               win_valid
);

    logic [IDX_W-1:0] w_cand;

    always_comb begin
        win_onehot = '0;
        win_idx    = '0;
        win_valid  = 1'b0;
        w_cand     = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            w_cand = IDX_W'((int'(ptr) + off) % NUM_REQ);
            if (!win_valid && req[w_cand]) begin
                win_valid          = 1'b1;
                win_idx            = w_cand;
                win_onehot[w_cand] = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Round-robin, packet-locking arbiter feeding one uart_sender.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int CLKS_PER_BIT = 434,
    parameter int STOP_BITS    = 1,
    parameter int LOCK_TIMEOUT = 65535
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic [NUM_REQ-1:0]                req_valid,
    input  logic [NUM_REQ*UART_DATA_BITS-1:0] req_data,
    input  logic [NUM_REQ-1:0]                req_last,
    output logic [NUM_REQ-1:0]                req_ready,
    output logic [UART_DATA_BITS-1:0]         tx_data,
    output logic                              tx_data_ready,
    output logic [NUM_REQ-1:0]                grant,
    output logic                              busy
);

    localparam int c_FRAME_CYCLES = frame_cycles(CLKS_PER_BIT, STOP_BITS);
    localparam int c_FRAME_W      = $clog2(c_FRAME_CYCLES);
    localparam int c_TO_W         = $clog2(LOCK_TIMEOUT + 1);
    localparam int c_IDX_W        = $clog2(NUM_REQ);

    arb_state_t                r_state;
    arb_state_t                w_state_nxt;
    logic [UART_DATA_BITS-1:0] r_tx_data;
    logic                      r_tx_data_ready;
    logic [NUM_REQ-1:0]        r_grant;
    logic [c_IDX_W-1:0]        r_ptr;
    logic                      r_lock;
    logic [c_FRAME_W-1:0]      r_frame_cnt;
    logic [c_TO_W-1:0]         r_to_cnt;

    logic [UART_DATA_BITS-1:0] w_bytes [NUM_REQ];
    logic [NUM_REQ-1:0]        w_win_onehot;
    logic [c_IDX_W-1:0]        w_win_idx;
    logic                      w_win_valid;
    logic                      w_accept;
    logic [c_IDX_W-1:0]        w_sel_idx;
    logic                      w_frame_done;
    logic                      w_to_expired;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_bytes
        assign w_bytes[gi] = req_data[gi*UART_DATA_BITS +: UART_DATA_BITS];
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (c_IDX_W)
    ) u_rr_pick (
        .req        (req_valid),
        .ptr        (r_ptr),
        .win_onehot (w_win_onehot),
        .win_idx    (w_win_idx),
        .win_valid  (w_win_valid)
    );

    assign w_frame_done = (r_frame_cnt == '0);
    assign w_to_expired = (r_to_cnt == c_TO_W'(LOCK_TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_sel_idx   = r_ptr;
        req_ready   = '0;
        case (r_state)
            IDLE: begin
                if (w_win_valid) begin
                    w_accept    = 1'b1;
                    w_sel_idx   = w_win_idx;
                    req_ready   = w_win_onehot;
                    w_state_nxt = SEND;
                end
            end
            SEND: w_state_nxt = WAIT;
            WAIT: begin
                if (w_frame_done) begin
                    w_state_nxt = r_lock ? LOCKED : IDLE;
                end
            end
            LOCKED: begin
                // While a packet is open the pointer doubles as the owner index.
                if (req_valid[r_ptr]) begin
                    w_accept         = 1'b1;
                    req_ready[r_ptr] = 1'b1;
                    w_state_nxt      = SEND;
                end else if (w_to_expired) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        if (!reset_n) begin
            req_ready = '0;
            w_accept  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tx_data       <= '0;
            r_tx_data_ready <= 1'b0;
            r_grant         <= '0;
            r_ptr           <= c_IDX_W'(NUM_REQ - 1);
            r_lock          <= 1'b0;
            r_frame_cnt     <= '0;
            r_to_cnt        <= '0;
        end else begin
            r_tx_data_ready <= w_accept;
            if (w_accept) begin
                r_tx_data <= w_bytes[w_sel_idx];
                r_lock    <= ~req_last[w_sel_idx];
            end
            if (r_state == IDLE && w_accept) begin
                r_grant <= w_win_onehot;
                r_ptr   <= w_win_idx;
            end

            // SEND plus the countdown from FRAME-2 to 0 spans one full frame.
            if (r_state == SEND) begin
                r_frame_cnt <= c_FRAME_W'(c_FRAME_CYCLES - 2);
            end else if (r_state == WAIT && !w_frame_done) begin
                r_frame_cnt <= r_frame_cnt - c_FRAME_W'(1);
            end
            if (r_state == WAIT && w_frame_done && !r_lock) begin
                r_grant <= '0;
            end

            if (w_accept) begin
                r_to_cnt <= '0;
            end else if (r_state == LOCKED) begin
                if (w_to_expired) begin
                    r_to_cnt <= '0;
                    r_lock   <= 1'b0;
                    r_grant  <= '0;
                end else begin
                    r_to_cnt <= r_to_cnt + c_TO_W'(1);
                end
            end
        end
    end

    assign tx_data       = r_tx_data;
    assign tx_data_ready = r_tx_data_ready;
    assign grant         = r_grant;
    assign busy          = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_arbiter
// Description : Self-checking bench for uart_tx_arbiter (timeline model).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int N     = 4;
    localparam int CPB   = 4;
    localparam int SB    = 1;
    localparam int TO    = 20;
    localparam int FRAME = CPB * (9 + SB);

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic [N-1:0]   req_valid;
    logic [N*8-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic [7:0]     tx_data;
    logic           tx_data_ready;
    logic [N-1:0]   grant;
    logic           busy;

    int checks   = 0;
    int failures = 0;

    logic [8:0]   src_mem [N][16];
    int           src_head [N] = '{default: 0};
    int           src_tail [N] = '{default: 0};
    logic [N-1:0] acc_mask = '0;

    int         cyc     = 0;
    int         m_acc   = -1000;
    int         m_owner = 0;
    int         m_ptr   = N - 1;
    logic       m_lock  = 1'b0;
    logic [7:0] m_byte  = 8'h00;
    int         busy_cnt = 0;

    int           pl_cyc   [$];
    logic [7:0]   pl_data  [$];
    logic [N-1:0] pl_grant [$];

    uart_tx_arbiter #(
        .NUM_REQ      (N),
        .CLKS_PER_BIT (CPB),
        .STOP_BITS    (SB),
        .LOCK_TIMEOUT (TO)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_last      (req_last),
        .req_ready     (req_ready),
        .tx_data       (tx_data),
        .tx_data_ready (tx_data_ready),
        .grant         (grant),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    // Model: a byte accepted at cycle A owns cycles A+1..A+FRAME; an open
    // packet then reserves A+FRAME+1..A+FRAME+TO for its owner only.
    initial begin : p_compare
        logic [N-1:0] exp_ready;
        logic         in_frame;
        logic         in_lock;
        int           w;
        forever begin
            @(negedge clk);
            cyc++;
            acc_mask = req_valid & req_ready;
            if (tx_data_ready) begin
                pl_cyc.push_back(cyc);
                pl_data.push_back(tx_data);
                pl_grant.push_back(grant);
            end
            if (busy) busy_cnt++;
            if (!reset_n) begin
                chk("rst_req_ready", 32'(req_ready), 32'h0);
                chk("rst_tx_data_ready", 32'(tx_data_ready), 32'h0);
                chk("rst_tx_data", 32'(tx_data), 32'h0);
                chk("rst_grant", 32'(grant), 32'h0);
                chk("rst_busy", 32'(busy), 32'h0);
                m_acc   = -1000;
                m_byte  = 8'h00;
                m_lock  = 1'b0;
                m_ptr   = N - 1;
                m_owner = 0;
            end else begin
                in_frame  = (cyc >= m_acc + 1) && (cyc <= m_acc + FRAME);
                in_lock   = m_lock && (cyc > m_acc + FRAME) && (cyc <= m_acc + FRAME + TO);
                exp_ready = '0;
                w         = -1;
                if (!in_frame) begin
                    if (in_lock) begin
                        if (req_valid[m_owner]) w = m_owner;
                    end else begin
                        for (int k = 1; k <= N; k++) begin
                            if (w < 0 && req_valid[(m_ptr + k) % N]) w = (m_ptr + k) % N;
                        end
                    end
                end
                if (w >= 0) exp_ready[w] = 1'b1;
                chk("req_ready", 32'(req_ready), 32'(exp_ready));
                chk("tx_data_ready", 32'(tx_data_ready), 32'(cyc == m_acc + 1));
                chk("tx_data", 32'(tx_data), 32'(m_byte));
                chk("grant", 32'(grant), (in_frame || in_lock) ? (32'd1 << m_owner) : 32'd0);
                chk("busy", 32'(busy), 32'(in_frame || in_lock));
                if (w >= 0) begin
                    m_acc   = cyc;
                    m_byte  = req_data[8*w +: 8];
                    m_owner = w;
                    if (!in_lock) m_ptr = w;
                    m_lock  = !req_last[w];
                end
            end
        end
    end

    initial begin : p_driver
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (acc_mask[i]) src_head[i]++;
                if (src_head[i] < src_tail[i]) begin
                    req_valid[i]       = 1'b1;
                    req_data[8*i +: 8] = src_mem[i][src_head[i]][7:0];
                    req_last[i]        = src_mem[i][src_head[i]][8];
                end else begin
                    req_valid[i]       = 1'b0;
                    req_data[8*i +: 8] = 8'h00;
                    req_last[i]        = 1'b0;
                end
            end
        end
    end

    task automatic push(input int r, input logic [7:0] d, input logic l);
        src_mem[r][src_tail[r]] = {l, d};
        src_tail[r]++;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic clear_logs();
        pl_cyc.delete();
        pl_data.delete();
        pl_grant.delete();
        busy_cnt = 0;
    endtask

    task automatic do_reset();
        step(1);
        reset_n = 1'b0;
        for (int i = 0; i < N; i++) begin
            src_head[i] = 0;
            src_tail[i] = 0;
        end
        step(3);
        reset_n = 1'b1;
        clear_logs();
        step(1);
    endtask

    task automatic wait_pulses(input int n, input string name);
        int budget = 0;
        while (pl_data.size() < n && budget < 500) begin
            step(1);
            budget++;
        end
        chk({name, "_pulse_count"}, 32'(pl_data.size() >= n), 32'd1);
    endtask

    initial begin : p_watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin : p_main
        logic [7:0]   exp6_d [5] = '{8'h01, 8'h31, 8'h02, 8'h32, 8'h03};
        logic [N-1:0] exp6_g [5] = '{4'b0001, 4'b1000, 4'b0001, 4'b1000, 4'b0001};

        // Single byte
        do_reset();
        push(0, 8'h41, 1'b1);
        wait_pulses(1, "t1");
        step(FRAME + 5);
        chk("t1_data", 32'(pl_data[0]), 32'h41);
        chk("t1_grant", 32'(pl_grant[0]), 32'b0001);
        chk("t1_busy_cycles", 32'(busy_cnt), 32'd40);
        chk("t1_pulses", 32'(pl_data.size()), 32'd1);

        // Round-robin among three requesters
        do_reset();
        push(0, 8'h10, 1'b1);
        push(1, 8'h20, 1'b1);
        push(2, 8'h30, 1'b1);
        wait_pulses(3, "t2");
        step(FRAME + 5);
        chk("t2_data0", 32'(pl_data[0]), 32'h10);
        chk("t2_data1", 32'(pl_data[1]), 32'h20);
        chk("t2_data2", 32'(pl_data[2]), 32'h30);
        chk("t2_grant1", 32'(pl_grant[1]), 32'b0010);
        chk("t2_grant2", 32'(pl_grant[2]), 32'b0100);
        chk("t2_gap01", 32'(pl_cyc[1] - pl_cyc[0]), 32'd41);
        chk("t2_gap12", 32'(pl_cyc[2] - pl_cyc[1]), 32'd41);

        // Packet lock holds off requester 0
        do_reset();
        push(1, 8'hA1, 1'b0);
        push(1, 8'hA2, 1'b0);
        push(1, 8'hA3, 1'b1);
        wait_pulses(1, "t3a");
        push(0, 8'h05, 1'b1);
        wait_pulses(4, "t3");
        step(FRAME + 5);
        chk("t3_data1", 32'(pl_data[1]), 32'hA2);
        chk("t3_data2", 32'(pl_data[2]), 32'hA3);
        chk("t3_grant2", 32'(pl_grant[2]), 32'b0010);
        chk("t3_data3", 32'(pl_data[3]), 32'h05);
        chk("t3_grant3", 32'(pl_grant[3]), 32'b0001);
        chk("t3_gap23", 32'(pl_cyc[3] - pl_cyc[2]), 32'd41);

        // Lock timeout releases the grant to requester 3
        do_reset();
        push(2, 8'hC2, 1'b0);
        push(3, 8'hD3, 1'b1);
        wait_pulses(2, "t4");
        step(FRAME + 5);
        chk("t4_data0", 32'(pl_data[0]), 32'hC2);
        chk("t4_data1", 32'(pl_data[1]), 32'hD3);
        chk("t4_grant1", 32'(pl_grant[1]), 32'b1000);
        chk("t4_gap", 32'(pl_cyc[1] - pl_cyc[0]), 32'd61);

        // Reset ten cycles into WAIT
        do_reset();
        push(0, 8'h55, 1'b1);
        wait_pulses(1, "t5a");
        step(10);
        chk("t5_busy_before", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("t5_tx_data_now", 32'(tx_data), 32'h0);
        chk("t5_grant_now", 32'(grant), 32'h0);
        chk("t5_busy_now", 32'(busy), 32'h0);
        chk("t5_tx_ready_now", 32'(tx_data_ready), 32'h0);
        clear_logs();
        step(3);
        reset_n = 1'b1;
        step(60);
        chk("t5_no_stale_pulse", 32'(pl_data.size()), 32'd0);
        push(1, 8'h66, 1'b1);
        push(0, 8'h77, 1'b1);
        wait_pulses(2, "t5");
        chk("t5_first_data", 32'(pl_data[0]), 32'h77);
        chk("t5_first_grant", 32'(pl_grant[0]), 32'b0001);
        chk("t5_second_data", 32'(pl_data[1]), 32'h66);

        // Fairness between a persistent requester 0 and requester 3
        do_reset();
        push(0, 8'h01, 1'b1);
        push(0, 8'h02, 1'b1);
        push(0, 8'h03, 1'b1);
        push(3, 8'h31, 1'b1);
        push(3, 8'h32, 1'b1);
        wait_pulses(5, "t6");
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("t6_data%0d", k), 32'(pl_data[k]), 32'(exp6_d[k]));
            chk($sformatf("t6_grant%0d", k), 32'(pl_grant[k]), 32'(exp6_g[k]));
        end
        step(FRAME + 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
